// File: rtl/riscv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_pkg: shared record format and TX state encoding for the store tap.
// Rev 1.0
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [7:0]  REC_SYNC_BYTE = 8'hA5;
    localparam int unsigned REC_LEN       = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [3:0]  en;
        logic [13:0] addr;
        logic [31:0] data;
    } store_rec_t;

    function automatic logic [7:0] rec_byte(input logic [2:0] idx, input store_rec_t rec);
        logic [7:0] b;
        b = REC_SYNC_BYTE;
        case (idx)
            3'd0:    b = REC_SYNC_BYTE;
            3'd1:    b = {rec.en, 4'b0000};
            3'd2:    b = {2'b00, rec.addr[13:8]};
            3'd3:    b = rec.addr[7:0];
            3'd4:    b = rec.data[31:24];
            3'd5:    b = rec.data[23:16];
            3'd6:    b = rec.data[15:8];
            default: b = rec.data[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_fifo: synchronous FIFO; push is refused when full before any pop.
// Rev 1.0
// ----------------------------------------------------------------------------
module store_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_data,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        o_full   = (count_q == (AW+1)'(DEPTH));
        o_empty  = (count_q == '0);
        do_push  = i_push && !o_full;
        do_pop   = i_pop && !o_empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/dmem_store_uart_tap.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dmem_store_uart_tap: captures core stores and streams 8-byte 8N1 records.
// Rev 1.0
// ----------------------------------------------------------------------------
module dmem_store_uart_tap
    import riscv_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [13:0]                  i_dmem_addr,
    input  logic [31:0]                  i_dmem_write_data,
    input  logic [3:0]                   i_dmem_write_enable,
    output logic                         o_uart_tx,
    output logic                         o_busy,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
    output logic                         o_overflow
);
    localparam int             DIV      = CLK_FREQ_HZ / BAUD;
    localparam int             CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  DIV_LOAD = CW'(DIV - 1);
    localparam logic [2:0]     LAST_BYTE = 3'(REC_LEN - 1);

    tx_state_t     state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic          tx_q, tx_d;
    logic          overflow_q, overflow_d;

    logic          push, pop, bit_end;
    logic          fifo_full, fifo_empty;
    store_rec_t    push_rec, head;
    logic [7:0]    cur_byte;

    assign push     = |i_dmem_write_enable;
    assign push_rec = '{en: i_dmem_write_enable, addr: i_dmem_addr, data: i_dmem_write_data};

    store_fifo #(
        .WIDTH ($bits(store_rec_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (push),
        .i_data  (push_rec),
        .i_pop   (pop),
        .o_data  (head),
        .o_count (o_fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // The head entry is only released by pop, so it stays stable for the whole record.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        overflow_d = overflow_q | (push & fifo_full);
        cur_byte   = rec_byte(byte_q, head);
        bit_end    = (div_q == '0);

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    state_d = TX_START;
                    tx_d    = 1'b0;
                    div_d   = DIV_LOAD;
                    byte_d  = 3'd0;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    tx_d    = cur_byte[0];
                    bit_d   = 3'd0;
                    div_d   = DIV_LOAD;
                end else begin
                    div_d = div_q - CW'(1);
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    div_d = DIV_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    div_d = div_q - CW'(1);
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (byte_q == LAST_BYTE) begin
                        state_d = TX_IDLE;
                        pop     = 1'b1;
                        tx_d    = 1'b1;
                        byte_d  = 3'd0;
                    end else begin
                        state_d = TX_START;
                        byte_d  = byte_q + 3'd1;
                        tx_d    = 1'b0;
                        div_d   = DIV_LOAD;
                    end
                end else begin
                    div_d = div_q - CW'(1);
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= TX_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign o_uart_tx  = tx_q;
    assign o_busy     = (state_q != TX_IDLE);
    assign o_overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_uart_tap.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dmem_store_uart_tap: scoreboard bench decoding the UART line byte by byte.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_dmem_store_uart_tap;

    localparam int DIVC  = 10;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] i_dmem_addr = '0;
    logic [31:0] i_dmem_write_data = '0;
    logic [3:0]  i_dmem_write_enable = '0;
    logic        o_uart_tx;
    logic        o_busy;
    logic [4:0]  o_fifo_count;
    logic        o_overflow;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    int          rx_count = 0;
    int          peak = 0;

    always #5 clk = ~clk;

    dmem_store_uart_tap #(
        .CLK_FREQ_HZ (100_000_000),
        .BAUD        (10_000_000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .i_dmem_addr         (i_dmem_addr),
        .i_dmem_write_data   (i_dmem_write_data),
        .i_dmem_write_enable (i_dmem_write_enable),
        .o_uart_tx           (o_uart_tx),
        .o_busy              (o_busy),
        .o_fifo_count        (o_fifo_count),
        .o_overflow          (o_overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [3:0] en, input logic [13:0] addr, input logic [31:0] data);
        exp_q.push_back(8'hA5);
        exp_q.push_back({en, 4'b0000});
        exp_q.push_back({2'b00, addr[13:8]});
        exp_q.push_back(addr[7:0]);
        exp_q.push_back(data[31:24]);
        exp_q.push_back(data[23:16]);
        exp_q.push_back(data[15:8]);
        exp_q.push_back(data[7:0]);
    endtask

    // Holds the store for exactly one rising edge; caller clears or chains the next one.
    task automatic store(input logic [3:0] en, input logic [13:0] addr, input logic [31:0] data,
                         input bit accept);
        i_dmem_write_enable = en;
        i_dmem_addr         = addr;
        i_dmem_write_data   = data;
        if (accept) push_expected(en, addr, data);
        tick();
    endtask

    task automatic idle_in();
        i_dmem_write_enable = '0;
        i_dmem_addr         = '0;
        i_dmem_write_data   = '0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_count < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("rx_wait", rx_count >= target, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((o_busy || o_fifo_count != 0) && n < budget) begin
            tick();
            n++;
        end
        check_eq("idle_wait", o_busy || (o_fifo_count != 0), 0);
    endtask

    // UART receiver: every bit must hold its value for exactly DIVC cycles.
    initial begin : monitor
        bit         active = 0;
        int         cyc = 0;
        bit         ok = 1;
        logic       cur_bit = 1'b1;
        logic [7:0] rx_byte = '0;
        logic [7:0] e;
        int         k;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                active = 0;
            end else begin
                if (int'(o_fifo_count) > peak) peak = int'(o_fifo_count);
                if (!active && o_uart_tx == 1'b0) begin
                    active = 1;
                    cyc    = 0;
                    ok     = 1;
                end
                if (active) begin
                    k = cyc / DIVC;
                    if (cyc % DIVC == 0) begin
                        cur_bit = o_uart_tx;
                        if (k == 0 && o_uart_tx !== 1'b0) ok = 0;
                        if (k == 9 && o_uart_tx !== 1'b1) ok = 0;
                        if (k >= 1 && k <= 8) rx_byte[k-1] = o_uart_tx;
                    end else if (o_uart_tx !== cur_bit) begin
                        ok = 0;
                    end
                    if (cyc == 10 * DIVC - 1) begin
                        active = 0;
                        check_eq("rx_bit_width", ok, 1);
                        if (exp_q.size() == 0) begin
                            check_eq("rx_extra_byte", exp_q.size(), 1);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("rx_byte", rx_byte, e);
                        end
                        rx_count++;
                    end else begin
                        cyc++;
                    end
                end
            end
        end
    end

    initial begin : stim
        int base;
        int lat;
        int cyc;
        bit low_seen;

        repeat (3) tick();
        check_eq("rst_tx", o_uart_tx, 1);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_count", o_fifo_count, 0);
        check_eq("rst_overflow", o_overflow, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single full-enable record with latency and duration
        base = rx_count;
        store(4'hF, 14'h0123, 32'hDEADBEEF, 1);
        idle_in();
        lat = 1;
        while (o_uart_tx && lat < 8) begin
            tick();
            lat++;
        end
        check_eq("start_latency_le2", lat <= 2, 1);
        cyc = 0;
        while (o_busy && cyc < 2000) begin
            tick();
            cyc++;
        end
        check_eq("record_cycles", cyc, 800);
        check_eq("busy_after_record", o_busy, 0);
        check_eq("rec1_bytes", rx_count - base, 8);
        check_eq("rec1_drained", exp_q.size(), 0);

        // Partial enable, address at top of range
        store(4'h3, 14'h3FFF, 32'h000000FF, 1);
        idle_in();
        wait_idle(1200);
        check_eq("rec2_drained", exp_q.size(), 0);

        // Push on the pop edge with three queued entries
        base = rx_count;
        store(4'hF, 14'h0011, 32'h11111111, 1);
        store(4'hC, 14'h0022, 32'h22222222, 1);
        store(4'h1, 14'h0033, 32'h33333333, 1);
        idle_in();
        check_eq("pp_count_before", o_fifo_count, 3);
        wait_rx(base + 8, 1500);
        store(4'h6, 14'h0044, 32'h44444444, 1);
        idle_in();
        check_eq("pp_count_after", o_fifo_count, 3);
        wait_idle(4000);
        check_eq("pp_drained", exp_q.size(), 0);

        // Overflow: 20 back-to-back stores, only the first 16 survive
        peak = 0;
        for (int i = 0; i < 20; i++) begin
            store(4'hF, 14'(i), 32'h1000_0000 + i, i < DEPTH);
        end
        idle_in();
        check_eq("ovf_count_full", o_fifo_count, DEPTH);
        check_eq("ovf_flag", o_overflow, 1);
        wait_idle(DEPTH * 820);
        check_eq("ovf_peak", peak, DEPTH);
        check_eq("ovf_sticky", o_overflow, 1);
        check_eq("ovf_drained", exp_q.size(), 0);

        // Reset during the DATA state of byte 4
        base = rx_count;
        store(4'hF, 14'h02AA, 32'h12345678, 1);
        idle_in();
        wait_rx(base + 4, 600);
        repeat (45) tick();
        check_eq("mid_busy_before", o_busy, 1);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", o_uart_tx, 1);
        check_eq("mid_rst_count", o_fifo_count, 0);
        check_eq("mid_rst_busy", o_busy, 0);
        check_eq("mid_rst_overflow", o_overflow, 0);
        exp_q.delete();
        repeat (3) tick();
        reset_n = 1'b1;
        base = rx_count;
        low_seen = 0;
        repeat (300) begin
            tick();
            if (!o_uart_tx) low_seen = 1;
        end
        check_eq("post_rst_silent", low_seen, 0);
        check_eq("post_rst_no_bytes", rx_count - base, 0);
        check_eq("post_rst_busy", o_busy, 0);

        // New store after reset is transmitted normally
        store(4'hA, 14'h0001, 32'hCAFEF00D, 1);
        idle_in();
        wait_idle(1200);
        check_eq("final_drained", exp_q.size(), 0);
        check_eq("final_tx_idle", o_uart_tx, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
